// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits resolved as STAGES slices, one per stage.
// Optional signed saturation on overflow when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned Last = STAGES - 1;

    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];

    // Per-stage inputs: stage 0 sees the ports, stage k sees the registers of stage k-1.
    logic             st_v [STAGES];
    logic             st_c [STAGES];
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic [SW:0]      slice [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];

    logic             adv;
    logic             msb_cin;
    logic             fin_ovf;
    logic             fin_zero;
    logic [WIDTH-1:0] fin_sum;
    logic             ovf_q;
    logic             zero_q;

    assign adv      = !valid_q[Last] || out_ready;
    assign in_ready = adv;

    assign st_v[0] = in_valid;
    assign st_a[0] = a;
    assign st_b[0] = sub ? ~b : b;
    assign st_c[0] = sub ? 1'b1 : carry_in;
    assign st_s[0] = '0;

    genvar k;
    for (k = 1; k < STAGES; k++) begin : g_link
        assign st_v[k] = valid_q[k-1];
        assign st_a[k] = a_q[k-1];
        assign st_b[k] = b_q[k-1];
        assign st_c[k] = carry_q[k-1];
        assign st_s[k] = sum_q[k-1];
    end

    for (k = 0; k < STAGES; k++) begin : g_slice
        assign slice[k] = {1'b0, st_a[k][k*SW +: SW]} + {1'b0, st_b[k][k*SW +: SW]}
                        + {{SW{1'b0}}, st_c[k]};
        assign sum_d[k] = st_s[k] | (WIDTH'(slice[k][SW-1:0]) << (k * SW));
    end

    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    assign msb_cin = st_a[Last][WIDTH-1] ^ st_b[Last][WIDTH-1] ^ sum_d[Last][WIDTH-1];
    assign fin_ovf = msb_cin ^ slice[Last][SW];

`ifdef PIPELINED_ADDER_SAT_EN
    always_comb begin
        fin_sum = sum_d[Last];
        if (fin_ovf) begin
            fin_sum = st_a[Last][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign fin_sum = sum_d[Last];
`endif

    assign fin_zero = (fin_sum == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                carry_q[i] <= 1'b0;
                sum_q[i]   <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_q[i] <= st_v[i];
                carry_q[i] <= slice[i][SW];
                a_q[i]     <= st_a[i];
                b_q[i]     <= st_b[i];
                sum_q[i]   <= (i == Last) ? fin_sum : sum_d[i];
            end
            ovf_q  <= fin_ovf;
            zero_q <= fin_zero;
        end
    end

    assign out_valid = valid_q[Last];
    assign sum       = sum_q[Last];
    assign carry_out = carry_q[Last];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4): directed vectors plus
// stall, full-rate and reset-in-flight sequences.
module tb_pipelined_adder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    pipelined_adder #(
        .WIDTH (32),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 33-bit add, overflow from operand/result signs.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        logic [31:0] yy;
        logic [32:0] full;
        logic [31:0] r;
        logic        ov;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : c)};
        r    = full[31:0];
        ov   = (x[31] == yy[31]) && (r[31] != x[31]);
`ifdef PIPELINED_ADDER_SAT_EN
        if (ov) r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {r, full[32], ov, (r == 32'd0)};
    endfunction

    // One operation through an idle pipeline; checks latency and all result fields.
    task automatic single_op(input string tag, input vec_t v);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; a = v.a; b = v.b; carry_in = v.cin; sub = v.sub; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, 64'(sum), 64'(v.s));
        chk({tag, "_cout"}, 64'(carry_out), 64'(v.co));
        chk({tag, "_ovf"}, 64'(overflow), 64'(v.ov));
        chk({tag, "_zero"}, 64'(zero), 64'(v.z));
    endtask

    // Stream n random ops; inputs and outputs are observed at negedge, away from the clock edge.
    task automatic run_stream(input string tag, input int n, input bit rand_rdy);
        logic [34:0] exp_q [$];
        logic [34:0] e;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          in_stalls = 0;
        bit          held_v = 1'b0;
        logic [31:0] held_sum = '0;
        while ((sent < n || got < n) && cyc < 400) begin
            @(posedge clk); #1;
            in_valid  = (sent < n);
            a         = $urandom;
            b         = $urandom;
            carry_in  = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (held_v) begin
                chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                chk({tag, "_hold_sum"}, 64'(sum), 64'(held_sum));
            end
            held_v   = out_valid && !out_ready;
            held_sum = sum;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_out"}, 64'(sum), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_result"}, 64'({sum, carry_out, overflow, zero}), 64'(e));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, carry_in, sub));
                sent++;
            end else if (in_valid) begin
                in_stalls++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 64'(got), 64'(n));
        chk({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
        if (!rand_rdy) begin
            chk({tag, "_in_stalls"}, 64'(in_stalls), 64'd0);
            chk({tag, "_cycles"}, 64'(cyc), 64'(n + 4));
        end
    endtask

    initial begin
        vec_t v;
        bit   leak;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
`ifdef PIPELINED_ADDER_SAT_EN
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
`endif
        vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_000A, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0009, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flags", 64'({carry_out, overflow, zero}), 64'd0);

        for (int i = 0; i < 10; i++) begin
            single_op($sformatf("vec%0d", i), vecs[i]);
        end

        run_stream("stall_stream", 8, 1'b1);
        run_stream("full_rate", 12, 1'b0);

        // Three ops in flight, then reset with a fourth op offered in the same cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 32'(i + 1); b = 32'd100; carry_in = 1'b0; sub = 1'b0;
        end
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b1; a = 32'd7; b = 32'd7;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_sum", 64'(sum), 64'd0);
        leak = out_valid;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            leak = leak | out_valid;
        end
        chk("midrst_no_output", 64'(leak), 64'd0);
        v = '{32'h0000_0040, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0042, 1'b0, 1'b0, 1'b0};
        single_op("after_rst", v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
